// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port between the primary pipeline
// writeback (P) and the multi-cycle unit writeback (M). It also keeps a
// pending-write scoreboard so that decode can stall on registers whose M
// result has not landed yet. Writes to register 0 finish their handshake but
// are never presented to the register file, because the file does not
// hardwire r0.
//
// Handshake (P and M): a transfer completes in a cycle where valid && ready.
// A requester holds valid, reg and data stable until ready. The ready signals
// are combinational and depend only on the two valids and the starvation
// counter. At most one ready is high in any cycle.
//
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   p_valid/p_reg/p_data primary writeback request
//   p_ready              primary grant this cycle (combinational)
//   m_valid/m_reg/m_data multi-cycle unit writeback request
//   m_ready              M grant this cycle (combinational)
//   issue_valid/reg      an M op was issued; mark its destination pending
//   R_reg1, R_reg2       scoreboard query indices
//   busy1, busy2         pending M write to R_reg1 / R_reg2 (combinational)
//   W, W_reg, W_data     register file write port (registered, latency 1)
//   sb_err               sticky scoreboard protocol error
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          p_valid,
    input  logic [AW-1:0] p_reg,
    input  logic [DW-1:0] p_data,
    output logic          p_ready,
    input  logic          m_valid,
    input  logic [AW-1:0] m_reg,
    input  logic [DW-1:0] m_data,
    output logic          m_ready,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_reg,
    input  logic [AW-1:0] R_reg1,
    input  logic [AW-1:0] R_reg2,
    output logic          busy1,
    output logic          busy2,
    output logic          W,
    output logic [AW-1:0] W_reg,
    output logic [DW-1:0] W_data,
    output logic          sb_err
);

    localparam int          NREG       = 1 << AW;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    // Registered state
    logic [3:0]      starve_q, starve_d;
    logic [NREG-1:0] sb_q,     sb_d;
    logic            w_q,      w_d;
    logic [AW-1:0]   w_reg_q,  w_reg_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic            err_q,    err_d;

    // Combinational helpers
    logic            starve_hit;
    logic            p_grant;
    logic            m_grant;
    logic [AW-1:0]   sel_reg;
    logic [DW-1:0]   sel_data;
    logic            issue_set;

    // ------------------------------------------------------------------
    // Arbitration: P wins by default. Once M has been refused STARVE_MAX
    // cycles in a row, M wins the next cycle it is still valid.
    // ------------------------------------------------------------------
    always_comb begin
        starve_hit = (starve_q == STARVE_LIM);
        m_grant    = m_valid && (!p_valid || starve_hit);
        p_grant    = p_valid && !m_grant;
    end

    assign p_ready = p_grant;
    assign m_ready = m_grant;

    // The counter only counts cycles where M waits. It holds while M is idle,
    // so a burst of P traffic with no M request does not pre-charge it.
    always_comb begin
        starve_d = starve_q;
        if (m_grant) begin
            starve_d = '0;
        end else if (m_valid && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Write port: the granted transfer lands one cycle later. r0 writes
    // complete the handshake but leave W low and the index/data untouched.
    // ------------------------------------------------------------------
    always_comb begin
        sel_reg  = m_grant ? m_reg  : p_reg;
        sel_data = m_grant ? m_data : p_data;
        w_d      = (p_grant || m_grant) && (sel_reg != '0);
        w_reg_d  = w_reg_q;
        w_data_d = w_data_q;
        if (w_d) begin
            w_reg_d  = sel_reg;
            w_data_d = sel_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. The clear is applied before the set, so a same-cycle
    // issue and M completion to one register leaves it pending. P writes
    // never touch the scoreboard.
    // ------------------------------------------------------------------
    always_comb begin
        issue_set = issue_valid && (issue_reg != '0);
        sb_d      = sb_q;
        if (m_grant) begin
            sb_d[m_reg] = 1'b0;
        end
        if (issue_set) begin
            sb_d[issue_reg] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // A re-issue to a pending register is legal only if that register is
    // retired in the same cycle. An M completion must find its bit set.
    always_comb begin
        err_d = err_q;
        if (issue_set && sb_q[issue_reg] && !(m_grant && (m_reg == issue_reg))) begin
            err_d = 1'b1;
        end
        if (m_grant && !sb_q[m_reg]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_q <= '0;
            sb_q     <= '0;
            w_q      <= 1'b0;
            w_reg_q  <= '0;
            w_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            sb_q     <= sb_d;
            w_q      <= w_d;
            w_reg_q  <= w_reg_d;
            w_data_q <= w_data_d;
            err_q    <= err_d;
        end
    end

    assign busy1  = (R_reg1 != '0) && sb_q[R_reg1];
    assign busy2  = (R_reg2 != '0) && sb_q[R_reg2];
    assign W      = w_q;
    assign W_reg  = w_reg_q;
    assign W_data = w_data_q;
    assign sb_err = err_q;

endmodule
